// File: rtl/dccm_resp.sv
// dccm_resp: far-end responder for the core's DCCM port.
// Word-organised SRAM with byte-enable stores and 1-cycle registered loads.
// After reset, an INIT sweep zeroes the array before any traffic is accepted.
// Optional feature macro: DCCM_PARITY_EN (per-lane even parity with read check).
//
// state    | meaning
// ---------+------------------------------------------------
// ST_INIT  | zero-fill sweep, one word per cycle, traffic ignored
// ST_READY | normal load/store service
module dccm_resp #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dccm_wr_en,
  input  logic        dccm_rd_en,
  input  logic [31:0] dccm_wr_addr,
  input  logic [31:0] dccm_rd_addr,
  input  logic [31:0] dccm_wr_data,
  input  logic [1:0]  store_type,
  input  logic [1:0]  store_offset,
  output logic [31:0] dccm_rd_data,
  output logic        init_done,
  output logic        access_err,
  output logic [31:0] err_addr,
  output logic        parity_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic ST_INIT  = 1'b0;
  localparam logic ST_READY = 1'b1;

  logic                  state;
  logic [DEPTH_LOG2-1:0] init_cnt;
  logic [31:0]           mem [DEPTH];

  logic                  ready;
  logic [31:0]           wr_off;
  logic [31:0]           rd_off;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  legal;
  logic [3:0]            be;
  logic [31:0]           wr_shift;
  logic [31:0]           merged;
  logic                  wr_ok;
  logic                  wr_err;
  logic                  rd_ok;
  logic                  rd_err;
  logic                  collide;
  logic [31:0]           rd_word;
  logic                  par_bad;

  assign ready = (state == ST_READY);

  // Offsetting by the base turns addresses below the window into huge values,
  // so a single upper-bits-zero test covers both ends of the range.
  assign wr_off      = dccm_wr_addr - BASE_ADDR;
  assign rd_off      = dccm_rd_addr - BASE_ADDR;
  assign wr_in_range = (wr_off[31:DEPTH_LOG2+2] == '0);
  assign rd_in_range = (rd_off[31:DEPTH_LOG2+2] == '0);
  assign wr_idx      = wr_off[DEPTH_LOG2+1:2];
  assign rd_idx      = rd_off[DEPTH_LOG2+1:2];

  // Store legality and byte-lane enables from type/offset.
  always_comb begin
    legal = 1'b0;
    be    = 4'b0000;
    case (store_type)
      2'b00: begin
        legal = 1'b1;
        be    = 4'b0001 << store_offset;
      end
      2'b01: begin
        legal = ~store_offset[0];
        be    = 4'b0011 << store_offset;
      end
      2'b10: begin
        legal = (store_offset == 2'b00);
        be    = 4'b1111;
      end
      default: begin
        legal = 1'b0;
        be    = 4'b0000;
      end
    endcase
  end

  assign wr_shift = dccm_wr_data << {store_offset, 3'b000};

  assign wr_ok  = ready & dccm_wr_en & legal & wr_in_range;
  assign wr_err = ready & dccm_wr_en & ~(legal & wr_in_range);
  assign rd_ok  = ready & dccm_rd_en & rd_in_range;
  assign rd_err = ready & dccm_rd_en & ~rd_in_range;

  // Merge the selected lanes of the store into the current word.
  always_comb begin
    merged = mem[wr_idx];
    for (int j = 0; j < 4; j++) begin
      if (be[j]) merged[8*j +: 8] = wr_shift[8*j +: 8];
    end
  end

  // Write-first: a load that hits the word being stored sees the merged word.
  assign collide = wr_ok & (wr_idx == rd_idx);
  assign rd_word = collide ? merged : mem[rd_idx];

`ifdef DCCM_PARITY_EN
  logic [3:0] par_mem [DEPTH];
  logic [3:0] merged_par;
  logic [3:0] rd_par;
  logic [3:0] calc_par;

  // Parity bits follow their lanes; unselected lanes keep their stored bit.
  always_comb begin
    merged_par = par_mem[wr_idx];
    calc_par   = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      if (be[j]) merged_par[j] = ^wr_shift[8*j +: 8];
      calc_par[j] = ^rd_word[8*j +: 8];
    end
  end

  assign rd_par  = collide ? merged_par : par_mem[rd_idx];
  assign par_bad = rd_ok & (rd_par != calc_par);

  // Parity storage: cleared by the sweep, updated per lane on legal stores.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        par_mem[init_cnt] <= 4'b0000;
      end else if (wr_ok) begin
        par_mem[wr_idx] <= merged_par;
      end
    end
  end
`else
  assign par_bad = 1'b0;
`endif

  // Data array: zero-fill during INIT, lane-merged stores once ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[init_cnt] <= 32'h0000_0000;
      end else if (wr_ok) begin
        mem[wr_idx] <= merged;
      end
    end
  end

  // Sequencing, load data and error reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_INIT;
      init_cnt     <= '0;
      init_done    <= 1'b0;
      dccm_rd_data <= 32'h0000_0000;
      access_err   <= 1'b0;
      err_addr     <= 32'h0000_0000;
      parity_err   <= 1'b0;
    end else begin
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == '1) begin
          state     <= ST_READY;
          init_done <= 1'b1;
        end
      end

      access_err <= wr_err | rd_err;
      parity_err <= par_bad;

      // A store error outranks a concurrent read error for the captured address.
      if (wr_err) begin
        err_addr <= {dccm_wr_addr[31:2], store_offset};
      end else if (rd_err || par_bad) begin
        err_addr <= dccm_rd_addr;
      end

      if (rd_ok) begin
        dccm_rd_data <= rd_word;
      end else if (rd_err) begin
        dccm_rd_data <= 32'h0000_0000;
      end
    end
  end

endmodule

// File: tb/tb_dccm_resp.sv
// Self-checking bench for dccm_resp (DEPTH_LOG2=4, base 0).
// Randomised traffic is checked against a word-array reference model that
// applies stores byte by byte and answers loads after the store (write-first).
module tb_dccm_resp;

  localparam int NWORDS = 16;
  localparam int NBYTES = 4 * NWORDS;

  logic        clk = 1'b0;
  logic        rst;
  logic        dccm_wr_en;
  logic        dccm_rd_en;
  logic [31:0] dccm_wr_addr;
  logic [31:0] dccm_rd_addr;
  logic [31:0] dccm_wr_data;
  logic [1:0]  store_type;
  logic [1:0]  store_offset;
  logic [31:0] dccm_rd_data;
  logic        init_done;
  logic        access_err;
  logic [31:0] err_addr;
  logic        parity_err;

  dccm_resp #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .dccm_wr_en   (dccm_wr_en),
    .dccm_rd_en   (dccm_rd_en),
    .dccm_wr_addr (dccm_wr_addr),
    .dccm_rd_addr (dccm_rd_addr),
    .dccm_wr_data (dccm_wr_data),
    .store_type   (store_type),
    .store_offset (store_offset),
    .dccm_rd_data (dccm_rd_data),
    .init_done    (init_done),
    .access_err   (access_err),
    .err_addr     (err_addr),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  logic [31:0] mdl [NWORDS];
  logic [31:0] exp_rd;
  logic [31:0] exp_eaddr;
  logic        exp_err;
  logic        exp_par;
  int          bad_idx = -1;
  int          n_err = 0;
  int          n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    dccm_wr_en   = 1'b0;
    dccm_rd_en   = 1'b0;
    dccm_wr_addr = '0;
    dccm_rd_addr = '0;
    dccm_wr_data = '0;
    store_type   = 2'b00;
    store_offset = 2'b00;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NWORDS; i++) mdl[i] = 32'h0;
    exp_rd    = 32'h0;
    exp_eaddr = 32'h0;
    exp_err   = 1'b0;
    exp_par   = 1'b0;
    bad_idx   = -1;
  endtask

  // One READY cycle: drive, predict, clock, compare on the falling edge.
  task automatic cycle(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [1:0] st, input logic [1:0] so,
                       input logic re, input logic [31:0] ra, input string tag);
    int   nb;
    int   widx;
    logic werr;
    logic rerr;
    logic pbad;
    werr = 1'b0;
    rerr = 1'b0;
    pbad = 1'b0;
    dccm_wr_en   = we;
    dccm_wr_addr = wa;
    dccm_wr_data = wd;
    store_type   = st;
    store_offset = so;
    dccm_rd_en   = re;
    dccm_rd_addr = ra;
    if (we) begin
      nb = 1 << st;
      if (st != 2'b11 && (int'(so) % nb) == 0 && wa < NBYTES) begin
        widx = int'(wa) / 4;
        for (int b = 0; b < nb; b++) mdl[widx][8*(int'(so)+b) +: 8] = wd[8*b +: 8];
        if (widx == bad_idx && so == 2'b00) bad_idx = -1;
      end else begin
        werr = 1'b1;
      end
    end
    if (re) begin
      if (ra < NBYTES) begin
        exp_rd = mdl[int'(ra) / 4];
        if (int'(ra) / 4 == bad_idx) pbad = 1'b1;
      end else begin
        exp_rd = 32'h0;
        rerr   = 1'b1;
      end
    end
    exp_err = werr | rerr;
    exp_par = pbad;
    if (werr) exp_eaddr = {wa[31:2], so};
    else if (rerr || pbad) exp_eaddr = ra;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".rd_data"}, dccm_rd_data, exp_rd);
    check({tag, ".access_err"}, {31'b0, access_err}, {31'b0, exp_err});
    check({tag, ".err_addr"}, err_addr, exp_eaddr);
    check({tag, ".parity_err"}, {31'b0, parity_err}, {31'b0, exp_par});
    check({tag, ".init_done"}, {31'b0, init_done}, 32'h1);
    idle_inputs();
  endtask

  task automatic apply_reset(input int ncyc, input string tag);
    rst = 1'b1;
    idle_inputs();
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    check({tag, ".rd_data"}, dccm_rd_data, 32'h0);
    check({tag, ".init_done"}, {31'b0, init_done}, 32'h0);
    check({tag, ".access_err"}, {31'b0, access_err}, 32'h0);
    check({tag, ".err_addr"}, err_addr, 32'h0);
    check({tag, ".parity_err"}, {31'b0, parity_err}, 32'h0);
    model_reset();
  endtask

  // Release reset while hammering a store and a load that must both be ignored.
  task automatic run_init(input string tag);
    int cnt;
    int bad_cycles;
    cnt = 0;
    bad_cycles = 0;
    dccm_wr_en   = 1'b1;
    dccm_wr_addr = 32'h3C;
    dccm_wr_data = 32'hFFFF_FFFF;
    store_type   = 2'b10;
    store_offset = 2'b00;
    dccm_rd_en   = 1'b1;
    dccm_rd_addr = 32'h3C;
    rst = 1'b0;
    while (cnt < 40) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
      if (dccm_rd_data !== 32'h0 || access_err !== 1'b0) bad_cycles++;
      if (init_done === 1'b1) break;
    end
    idle_inputs();
    check({tag, ".init_cycles"}, cnt, 16);
    check({tag, ".quiet_during_init"}, bad_cycles, 0);
  endtask

  logic [31:0] ra;
  logic [31:0] wa;

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();

    apply_reset(2, "reset");
    run_init("init");

    cycle(1'b0, 0, 0, 2'b00, 2'b00, 1'b1, 32'h3C, "init_store_lost");
    check("init_store_lost.val", dccm_rd_data, 32'h0);

    cycle(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 2'b00, 1'b0, 0, "st_word");
    cycle(1'b0, 0, 0, 2'b00, 2'b00, 1'b1, 32'h10, "ld_word");
    check("ld_word.val", dccm_rd_data, 32'hDEAD_BEEF);
    cycle(1'b0, 0, 0, 2'b00, 2'b00, 1'b0, 0, "hold");
    check("hold.val", dccm_rd_data, 32'hDEAD_BEEF);

    cycle(1'b1, 32'h10, 32'h0000_005A, 2'b00, 2'b10, 1'b0, 0, "st_byte");
    cycle(1'b0, 0, 0, 2'b00, 2'b00, 1'b1, 32'h10, "ld_byte");
    check("merge_byte.val", dccm_rd_data, 32'hDE5A_BEEF);
    cycle(1'b1, 32'h10, 32'h0000_1234, 2'b01, 2'b00, 1'b0, 0, "st_half");
    cycle(1'b0, 0, 0, 2'b00, 2'b00, 1'b1, 32'h10, "ld_half");
    check("merge_half.val", dccm_rd_data, 32'hDE5A_1234);

    cycle(1'b1, 32'h20, 32'hCAFE_F00D, 2'b10, 2'b00, 1'b1, 32'h20, "collide");
    check("collide.val", dccm_rd_data, 32'hCAFE_F00D);

    cycle(1'b1, 32'h24, 32'h0000_ABCD, 2'b01, 2'b01, 1'b0, 0, "half_off1");
    check("half_off1.err", {31'b0, access_err}, 32'h1);
    check("half_off1.addr", err_addr, 32'h0000_0025);
    cycle(1'b0, 0, 0, 2'b00, 2'b00, 1'b0, 0, "err_pulse_end");
    check("err_pulse_end.err", {31'b0, access_err}, 32'h0);
    cycle(1'b0, 0, 0, 2'b00, 2'b00, 1'b1, 32'h24, "half_off1_nochg");
    check("half_off1_nochg.val", dccm_rd_data, 32'h0);

    cycle(1'b0, 0, 0, 2'b00, 2'b00, 1'b1, 32'h40, "rd_oor_edge");
    check("rd_oor_edge.addr", err_addr, 32'h0000_0040);
    cycle(1'b0, 0, 0, 2'b00, 2'b00, 1'b1, 32'h4000, "rd_oor");
    check("rd_oor.val", dccm_rd_data, 32'h0);
    check("rd_oor.addr", err_addr, 32'h0000_4000);

    cycle(1'b1, 32'h30, 32'h1, 2'b11, 2'b01, 1'b1, 32'h50, "dual_err");
    check("dual_err.addr", err_addr, 32'h0000_0031);

    cycle(1'b1, 32'h40, 32'h1, 2'b10, 2'b00, 1'b0, 0, "st_oor");
    cycle(1'b1, 32'h3C, 32'h1234_5678, 2'b10, 2'b00, 1'b1, 32'h3C, "top_word");

    for (int n = 0; n < 400; n++) begin
      wa = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, NBYTES + 15));
      ra = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, NBYTES + 15));
      cycle(($urandom_range(0, 9) < 7), wa, $urandom(), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7), ra, "rand");
    end

    cycle(1'b1, 32'h14, 32'h7777_7777, 2'b10, 2'b00, 1'b0, 0, "pre_rst");
    dccm_wr_en   = 1'b1;
    dccm_wr_addr = 32'h18;
    dccm_wr_data = 32'h5555_5555;
    store_type   = 2'b10;
    apply_reset(1, "mid_rst");
    run_init("reinit");
    for (int i = 0; i < NWORDS; i++) begin
      cycle(1'b0, 0, 0, 2'b00, 2'b00, 1'b1, 32'(4 * i), "rezero");
    end
    check("rezero.val", dccm_rd_data, 32'h0);

`ifdef DCCM_PARITY_EN
    cycle(1'b1, 32'h8, 32'h0000_00FF, 2'b10, 2'b00, 1'b0, 0, "par_st");
    dut.par_mem[2][0] = ~dut.par_mem[2][0];
    bad_idx = 2;
    cycle(1'b0, 0, 0, 2'b00, 2'b00, 1'b1, 32'h8, "par_ld");
    check("par_ld.val", dccm_rd_data, 32'h0000_00FF);
    check("par_ld.perr", {31'b0, parity_err}, 32'h1);
    check("par_ld.addr", err_addr, 32'h0000_0008);
`else
    cycle(1'b1, 32'h8, 32'h0000_00FF, 2'b10, 2'b00, 1'b1, 32'h8, "nopar");
    check("nopar.perr", {31'b0, parity_err}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
